// File: rtl/fp_mul_pipe_if.sv
// rtl/fp_mul_pipe_if.sv - operand/result stream bundle for the pipelined FP multiplier
// master is the issue/writeback side, slave is the multiplier.
interface fp_mul_pipe_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] product;
  logic         overflow;
  logic         underflow;
  logic         invalid;
  logic         inexact;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, product, overflow, underflow, invalid, inexact
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, product, overflow, underflow, invalid, inexact
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - 3-stage parametrised floating-point multiplier, RNE, flush-to-zero
// S1 captures operands, S2 multiplies mantissas and sums exponents, S3 rounds and registers the result.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic         clk,
  input logic         rst,
  fp_mul_pipe_if.slave bus
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int EW2 = EXP_W + 2;
  localparam int PW  = 2 * MAN_W + 2;
  localparam logic [EXP_W-1:0]      EXP_ONES = '1;
  localparam logic signed [EW2-1:0] BIAS_S   = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW2-1:0] MAX_E    = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] ONE      = EW2'(1);
  localparam logic signed [EW2-1:0] ZERO     = '0;

  // {zero, inf, nan}; a zero exponent is treated as zero so subnormals flush.
  function automatic logic [2:0] classify(input logic [W-2:0] v);
    logic [EXP_W-1:0] e;
    logic             fnz;
    e   = v[W-2 -: EXP_W];
    fnz = |v[MAN_W-1:0];
    return {e == '0, (e == EXP_ONES) && !fnz, (e == EXP_ONES) && fnz};
  endfunction

  logic advance;
  logic out_valid_q;

  assign advance      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = advance;

  logic         s1_valid;
  logic [W-1:0] s1_x;
  logic [W-1:0] s1_y;
  logic [2:0]   cls_x;
  logic [2:0]   cls_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (advance) begin
      s1_valid <= bus.in_valid;
      s1_x     <= bus.x;
      s1_y     <= bus.y;
    end
  end

  assign cls_x = classify(s1_x[W-2:0]);
  assign cls_y = classify(s1_y[W-2:0]);

  logic                  s2_valid;
  logic                  s2_sign;
  logic [PW-1:0]         s2_mprod;
  logic signed [EW2-1:0] s2_exp;
  logic                  s2_nan;
  logic                  s2_inf;
  logic                  s2_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_x[W-1] ^ s1_y[W-1];
      s2_mprod <= PW'({1'b1, s1_x[MAN_W-1:0]}) * PW'({1'b1, s1_y[MAN_W-1:0]});
      s2_exp   <= $signed({2'b00, s1_x[W-2 -: EXP_W]}) + $signed({2'b00, s1_y[W-2 -: EXP_W]}) - BIAS_S;
      s2_nan   <= cls_x[0] | cls_y[0] | (cls_x[1] & cls_y[2]) | (cls_y[1] & cls_x[2]);
      s2_inf   <= cls_x[1] | cls_y[1];
      s2_zero  <= cls_x[2] | cls_y[2];
    end
  end

  logic [MAN_W-1:0]      n_frac;
  logic                  guard;
  logic                  sticky;
  logic signed [EW2-1:0] n_exp;
  logic [MAN_W:0]        r_sum;
  logic signed [EW2-1:0] r_exp;
  logic [W-1:0]          nxt_product;
  logic [3:0]            nxt_flags;

  always_comb begin
    if (s2_mprod[PW-1]) begin
      n_frac = s2_mprod[PW-2 -: MAN_W];
      guard  = s2_mprod[MAN_W];
      sticky = |s2_mprod[MAN_W-1:0];
      n_exp  = s2_exp + ONE;
    end else begin
      n_frac = s2_mprod[PW-3 -: MAN_W];
      guard  = s2_mprod[MAN_W-1];
      sticky = |s2_mprod[MAN_W-2:0];
      n_exp  = s2_exp;
    end
    r_sum = {1'b0, n_frac} + (MAN_W+1)'(guard & (sticky | n_frac[0]));
    // A carry out leaves the fraction bits at zero, so only the exponent moves.
    r_exp = r_sum[MAN_W] ? n_exp + ONE : n_exp;
  end

  // Flags packed as {overflow, underflow, invalid, inexact}.
  always_comb begin
    nxt_product = {s2_sign, r_exp[EXP_W-1:0], r_sum[MAN_W-1:0]};
    nxt_flags   = {3'b000, guard | sticky};
    if (s2_nan) begin
      nxt_product = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
      nxt_flags   = 4'b0010;
    end else if (s2_inf) begin
      nxt_product = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
      nxt_flags   = 4'b0000;
    end else if (s2_zero) begin
      nxt_product = {s2_sign, {(W-1){1'b0}}};
      nxt_flags   = 4'b0000;
    end else if (r_exp >= MAX_E) begin
      nxt_product = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
      nxt_flags   = 4'b1001;
    end else if (r_exp <= ZERO) begin
      nxt_product = {s2_sign, {(W-1){1'b0}}};
      nxt_flags   = 4'b0101;
    end
  end

  logic [W-1:0] product_q;
  logic [3:0]   flags_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      product_q   <= '0;
      flags_q     <= '0;
    end else if (advance) begin
      out_valid_q <= s2_valid;
      if (s2_valid) begin
        product_q <= nxt_product;
        flags_q   <= nxt_flags;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
  assign bus.overflow  = flags_q[3];
  assign bus.underflow = flags_q[2];
  assign bus.invalid   = flags_q[1];
  assign bus.inexact   = flags_q[0];
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - bench for fp_mul_pipe in single and half precision
module tb_fp_mul_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_mul_pipe_if #(.W(32)) sp_if();
  fp_mul_pipe_if #(.W(16)) hp_if();

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) u_sp (.clk(clk), .rst(rst), .bus(sp_if));
  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) u_hp (.clk(clk), .rst(rst), .bus(hp_if));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] p;
    logic [3:0]  fl;
  } res_t;

  typedef struct {
    bit          hp;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] p;
    logic [3:0]  fl;
  } vec_t;

  res_t sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Value-level model: exact integer product, normalise by magnitude, round by remainder.
  function automatic res_t ref_mul(input int ew, input int mw, input longint a, input longint b);
    res_t   r;
    longint maxe, bias, mmask, sa, sb, ea, eb, fa, fb, s, pr, q, rem, half, be;
    int     k;
    bit     nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    maxe  = (longint'(1) << ew) - 1;
    bias  = (longint'(1) << (ew - 1)) - 1;
    mmask = (longint'(1) << mw) - 1;
    sa = (a >> (ew + mw)) & 1;   sb = (b >> (ew + mw)) & 1;
    ea = (a >> mw) & maxe;       eb = (b >> mw) & maxe;
    fa = a & mmask;              fb = b & mmask;
    s  = sa ^ sb;
    nan_a = (ea == maxe) && (fa != 0);  nan_b = (eb == maxe) && (fb != 0);
    inf_a = (ea == maxe) && (fa == 0);  inf_b = (eb == maxe) && (fb == 0);
    zero_a = (ea == 0);                 zero_b = (eb == 0);
    r.fl = 4'b0000;
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
      r.p  = 32'((maxe << mw) | (longint'(1) << (mw - 1)));
      r.fl = 4'b0010;
    end else if (inf_a || inf_b) begin
      r.p = 32'((s << (ew + mw)) | (maxe << mw));
    end else if (zero_a || zero_b) begin
      r.p = 32'(s << (ew + mw));
    end else begin
      pr = ((longint'(1) << mw) | fa) * ((longint'(1) << mw) | fb);
      k = 0;
      while ((pr >> k) >= (longint'(2) << mw)) k++;
      q    = pr >> k;
      rem  = pr - (q << k);
      half = longint'(1) << (k - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (longint'(2) << mw)) begin
        q = q >> 1;
        k++;
      end
      be = ea + eb - bias - mw + k;
      if (be >= maxe) begin
        r.p  = 32'((s << (ew + mw)) | (maxe << mw));
        r.fl = 4'b1001;
      end else if (be <= 0) begin
        r.p  = 32'(s << (ew + mw));
        r.fl = 4'b0101;
      end else begin
        r.p  = 32'((s << (ew + mw)) | (be << mw) | (q & mmask));
        r.fl = {3'b000, rem != 0};
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_sp();
    logic [31:0] v;
    logic [7:0]  e;
    v = $urandom;
    case ($urandom_range(0, 15))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(1, 20));
      3:       e = 8'($urandom_range(230, 254));
      default: e = 8'($urandom_range(90, 165));
    endcase
    v[30:23] = e;
    if (e == 8'hFF && $urandom_range(0, 1) == 0) v[22:0] = '0;
    return v;
  endfunction

  // Scoreboard for the single-precision instance: push on accept, pop on transfer.
  always @(negedge clk) begin
    res_t r;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (sp_if.out_valid && sp_if.out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra actual=%0h required=none", sp_if.product);
        end else begin
          r = sb_q.pop_front();
          check("sb_product", sp_if.product, r.p);
          check("sb_flags", {sp_if.overflow, sp_if.underflow, sp_if.invalid, sp_if.inexact}, r.fl);
        end
      end
      if (sp_if.in_valid && sp_if.in_ready)
        sb_q.push_back(ref_mul(8, 23, sp_if.x, sp_if.y));
    end
  end

  task automatic apply(input int idx, input vec_t v);
    int          n;
    logic [31:0] p;
    logic [3:0]  fl;
    if (v.hp) begin
      hp_if.in_valid = 1'b1; hp_if.x = v.x[15:0]; hp_if.y = v.y[15:0];
    end else begin
      sp_if.in_valid = 1'b1; sp_if.x = v.x; sp_if.y = v.y;
    end
    @(posedge clk); #1;
    sp_if.in_valid = 1'b0;
    hp_if.in_valid = 1'b0;
    n = 1;
    while (!(v.hp ? hp_if.out_valid : sp_if.out_valid) && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    p  = v.hp ? {16'h0, hp_if.product} : sp_if.product;
    fl = v.hp ? {hp_if.overflow, hp_if.underflow, hp_if.invalid, hp_if.inexact}
              : {sp_if.overflow, sp_if.underflow, sp_if.invalid, sp_if.inexact};
    check($sformatf("vec%0d_latency", idx), n, 3);
    check($sformatf("vec%0d_product", idx), p, v.p);
    check($sformatf("vec%0d_flags", idx), fl, v.fl);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[12];
    logic [31:0] ops_x[5];
    logic [31:0] ops_y[5];
    int          issued, got, stall;
    bit          seen;

    vecs[0]  = '{0, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000};
    vecs[1]  = '{0, 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001};
    vecs[2]  = '{0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001};
    vecs[3]  = '{0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b0010};
    vecs[4]  = '{0, 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000};
    vecs[5]  = '{0, 32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000};
    vecs[6]  = '{0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b1001};
    vecs[7]  = '{0, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0101};
    vecs[8]  = '{0, 32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000};
    vecs[9]  = '{0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0010};
    vecs[10] = '{1, 32'h00003C00, 32'h00003C00, 32'h00003C00, 4'b0000};
    vecs[11] = '{1, 32'h00007BFF, 32'h00004000, 32'h00007C00, 4'b1001};

    sp_if.in_valid = 1'b0; sp_if.x = '0; sp_if.y = '0; sp_if.out_ready = 1'b1;
    hp_if.in_valid = 1'b0; hp_if.x = '0; hp_if.y = '0; hp_if.out_ready = 1'b1;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sp_out_valid", sp_if.out_valid, 0);
    check("rst_sp_product", sp_if.product, 0);
    check("rst_sp_flags", {sp_if.overflow, sp_if.underflow, sp_if.invalid, sp_if.inexact}, 0);
    check("rst_hp_out_valid", hp_if.out_valid, 0);
    check("rst_hp_product", hp_if.product, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", sp_if.in_ready, 1);

    for (int i = 0; i < 12; i++) apply(i, vecs[i]);

    // Back-to-back stream with a 4-cycle output stall after the first result.
    for (int i = 0; i < 5; i++) begin
      ops_x[i] = rand_sp();
      ops_y[i] = rand_sp();
    end
    issued = 0; got = 0; stall = 0; seen = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      if (sp_if.out_valid) seen = 1;
      if (seen && stall < 4 && sp_if.out_valid) begin
        sp_if.out_ready = 1'b0;
        stall++;
      end else begin
        sp_if.out_ready = 1'b1;
      end
      sp_if.in_valid = (issued < 5);
      sp_if.x = ops_x[issued % 5];
      sp_if.y = ops_y[issued % 5];
      #1;
      if (!sp_if.out_ready) begin
        check("stall_in_ready", sp_if.in_ready, 0);
        if (sb_q.size() > 0) check("stall_product", sp_if.product, sb_q[0].p);
      end
      if (sp_if.in_valid && sp_if.in_ready) issued++;
      if (sp_if.out_valid && sp_if.out_ready) got++;
      @(posedge clk); #1;
    end
    sp_if.in_valid = 1'b0;
    sp_if.out_ready = 1'b1;
    check("bp_issued", issued, 5);
    check("bp_results", got, 5);

    // Reset with operations in flight.
    for (int c = 0; c < 4; c++) begin
      sp_if.in_valid = 1'b1;
      sp_if.x = rand_sp();
      sp_if.y = rand_sp();
      @(posedge clk); #1;
    end
    sp_if.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", sp_if.out_valid, 0);
    check("midrst_product", sp_if.product, 0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("midrst_no_stale", sp_if.out_valid, 0);
    end

    // Randomised traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      sp_if.in_valid  = ($urandom_range(0, 3) != 0);
      sp_if.x         = rand_sp();
      sp_if.y         = rand_sp();
      sp_if.out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    sp_if.in_valid = 1'b0;
    sp_if.out_ready = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
    end
    check("drain_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
